// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode and state encodings shared by the LED sequencer.
package led_seq_pkg;
    typedef enum logic [1:0] {FILL = 2'd0, DOT = 2'd1, BOUNCE = 2'd2, BLINK = 2'd3} mode_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    function automatic int steps_for(mode_e m, int led_w, int blinks);
        return m == BLINK ? 2 * blinks : m == BOUNCE ? 2 * (led_w - 1) : led_w - 1;
    endfunction
endpackage

// File: rtl/led_sequencer_tick_divider.sv
// tick_divider: free-running prescaler that strobes tick while count sits at DIV-1.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt, cnt_d;

    always_comb cnt_d = (restart || !en || cnt == LAST) ? '0 : cnt + 1'b1;

    // tick is registered so it is high exactly in the cycle where cnt == LAST
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            tick <= en && !restart && cnt_d == LAST;
        end
    end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: runs one of four LED patterns, one step per prescaled tick.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W   = 8,
    parameter int CLK_HZ  = 100000000,
    parameter int STEP_MS = 500,
    parameter int BLINKS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done,
    output logic             tick
);
    localparam int DIV  = CLK_HZ / 1000 * STEP_MS;
    localparam int MAXS = (2 * (LED_W - 1) > 2 * BLINKS) ? 2 * (LED_W - 1) : 2 * BLINKS;
    localparam int SW   = $clog2(MAXS + 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [SW-1:0]     step_q, step_d, last_step;
    logic [LED_W-1:0]  led_d, led_step, led_init;
    logic              done_d;

    tick_divider #(.DIV(DIV)) u_div (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q == RUN),
        .restart (clear || start),
        .tick    (tick)
    );

    always_comb begin
        last_step = SW'(steps_for(mode_q, LED_W, BLINKS) - 1);
        led_init  = mode_e'(mode) == BLINK ? '1 : LED_W'(1);
        // bounce direction follows from how many steps have been taken
        led_step  = mode_q == FILL ? {led[LED_W-2:0], 1'b1} :
                    mode_q == DOT  ? led << 1 :
                    mode_q == BOUNCE ? (step_q < SW'(LED_W - 1) ? led << 1 : led >> 1) :
                    ~led;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        led_d   = led;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            step_d  = '0;
            led_d   = '0;
        end else if (start) begin
            state_d = RUN;
            mode_d  = mode_e'(mode);
            step_d  = '0;
            led_d   = led_init;
        end else if (state_q == RUN && tick) begin
            led_d   = led_step;
            step_d  = step_q + 1'b1;
            if (step_q == last_step) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= FILL;
            step_q  <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            led     <= led_d;
            busy    <= state_d == RUN;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: vector table, directed corner sequences and random run vs. a timing model.
module tb_led_sequencer;
    localparam int W = 4;
    localparam int DIV = 4;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic reset, clear, start;
    logic [1:0] mode;
    logic [W-1:0] led;
    logic busy, done, tick;

    int total_checks = 0;
    int passed = 0;
    int done_seen = 0;

    // model: 0 idle, 1 running, 2 finished; e = cycles elapsed since start accept
    int m_st = 0, m_e = 0, m_md = 0;

    typedef struct {
        logic c, s;
        logic [1:0] m;
        logic [W-1:0] led;
        logic busy, done, tick;
    } vec_t;
    vec_t tbl[16];

    led_sequencer #(.LED_W(W), .CLK_HZ(1000), .STEP_MS(4), .BLINKS(BL)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .mode(mode),
        .led(led), .busy(busy), .done(done), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic int ref_steps(int md);
        return md < 2 ? W - 1 : md == 2 ? 2 * (W - 1) : 2 * BL;
    endfunction

    function automatic logic [W-1:0] pat(int md, int k);
        case (md)
            0: return W'((1 << (k + 1)) - 1);
            1: return W'(1 << k);
            2: return W'(k <= W - 1 ? 1 << k : 1 << (2 * (W - 1) - k));
            default: return (k % 2 == 0) ? '1 : '0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic cycle(input logic r, input logic c, input logic s, input logic [1:0] m);
        int tot;
        reset = r; clear = c; start = s; mode = m;
        @(posedge clk);
        if (r || c) begin
            m_st = 0; m_e = 0;
        end else if (s) begin
            m_st = 1; m_e = 0; m_md = int'(m);
        end else if (m_st == 1) begin
            m_e++;
            if (m_e == ref_steps(m_md) * DIV) m_st = 2;
        end else if (m_st == 2) m_e++;
        #1;
        tot = ref_steps(m_md);
        chk("led", 32'(led), 32'(m_st == 0 ? '0 : pat(m_md, m_st == 2 ? tot : m_e / DIV)));
        chk("busy", 32'(busy), 32'(m_st == 1));
        chk("tick", 32'(tick), 32'(m_st == 1 && m_e % DIV == DIV - 1));
        chk("done", 32'(done), 32'(m_st == 2 && m_e == tot * DIV));
        if (done) done_seen++;
    endtask

    task automatic idle(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, m);
    endtask

    initial begin
        tbl[0]  = '{0, 1, 0, 4'b0001, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 4'b0001, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 4'b0001, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 4'b0001, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 4'b0011, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 4'b0011, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 4'b0011, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 4'b0011, 1, 0, 1};
        tbl[8]  = '{0, 0, 0, 4'b0111, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 4'b0111, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 4'b0111, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 4'b0111, 1, 0, 1};
        tbl[12] = '{0, 0, 0, 4'b1111, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 4'b1111, 0, 0, 0};
        tbl[14] = '{1, 1, 2, 4'b0000, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 4'b0000, 0, 0, 0};

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 3);
        idle(2, 0);

        // FILL run followed by clear+start, from the vector table
        for (int i = 0; i < 16; i++) begin
            cycle(0, tbl[i].c, tbl[i].s, tbl[i].m);
            chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
            chk($sformatf("tbl%0d_bdt", i), {29'd0, busy, done, tick},
                {29'd0, tbl[i].busy, tbl[i].done, tbl[i].tick});
        end

        // BOUNCE full run
        done_seen = 0;
        cycle(0, 0, 1, 2);
        idle(30, 0);
        chk("bounce_dones", 32'(done_seen), 32'd1);
        chk("bounce_final", 32'(led), 32'b0001);

        // BLINK with mode wiggled mid-run
        done_seen = 0;
        cycle(0, 0, 1, 3);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 2'(i));
        chk("blink_dones", 32'(done_seen), 32'd1);
        chk("blink_final", 32'(led), 32'b1111);

        // DOT restarted on the second tick
        done_seen = 0;
        cycle(0, 0, 1, 1);
        idle(7, 0);
        chk("dot_tick2", 32'(tick), 32'd1);
        cycle(0, 0, 1, 1);
        chk("dot_restart_led", 32'(led), 32'b0001);
        idle(3, 0);
        chk("dot_next_tick", 32'(tick), 32'd1);
        chk("dot_no_done_yet", 32'(done_seen), 32'd0);
        idle(12, 0);
        chk("dot_dones", 32'(done_seen), 32'd1);
        cycle(0, 1, 1, 1);
        chk("clr_start_led", 32'(led), 32'd0);

        // reset after the second tick aborts silently
        done_seen = 0;
        cycle(0, 0, 1, 0);
        idle(8, 0);
        cycle(1, 0, 0, 0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        idle(3, 0);
        chk("rst_no_done", 32'(done_seen), 32'd0);
        cycle(0, 0, 1, 0);
        idle(15, 0);
        chk("rst_rerun_dones", 32'(done_seen), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(199) == 0, $urandom_range(99) == 0,
                  $urandom_range(29) == 0, 2'($urandom));

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end
endmodule
